ps2_mouse_ctrl: RTL and testbench

//  Packet-layer PS/2 mouse controller above the ps2_rxtx byte transceiver. Resets and inits the mouse,

---
 rtl/ps2_mouse_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_ps2_mouse_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ps2_mouse_ctrl
// Brief    : PS/2 mouse init/packet layer above a byte transceiver; define
//            PS2_MOUSE_ACCUM_EN to build the clamped cursor accumulator.
// Revision : 1.0  initial release
// ============================================================================
module ps2_mouse_ctrl #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TIMEOUT_MS = 20,
    parameter int WHEEL      = 1,
    parameter int POS_W      = 10,
    parameter int X_MAX      = 639,
    parameter int Y_MAX      = 479
) (
    input  logic             clk,
    input  logic             reset,
    output logic             tx_req,
    output logic [7:0]       tx_byte,
    input  logic             tx_done,
    input  logic             rx_done,
    input  logic [7:0]       rx_byte,
    output logic             ready,
    output logic             wheel_mode,
    output logic             pkt_valid,
    output logic [8:0]       dx,
    output logic [8:0]       dy,
    output logic [3:0]       dz,
    output logic [2:0]       buttons,
    output logic [1:0]       ovf,
    output logic [7:0]       err_cnt,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y
);

    localparam int c_to_cycles = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int c_to_w      = $clog2(c_to_cycles + 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(c_to_cycles - 1);
    localparam logic signed [POS_W+1:0] c_x_max = (POS_W+2)'(X_MAX);
    localparam logic signed [POS_W+1:0] c_y_max = (POS_W+2)'(Y_MAX);

    typedef enum logic [3:0] {
        ST_RST_TX, ST_RST_ACK, ST_BAT, ST_ID0, ST_SR_TX, ST_SR_ACK,
        ST_ID_TX, ST_ID_ACK, ST_ID_RX, ST_EN_TX, ST_EN_ACK, ST_STREAM
    } state_t;

    state_t            state_q, state_d, w_tx_next;
    logic              sent_q, sent_d, armed_q, armed_d;
    logic [2:0]        sr_idx_q, sr_idx_d;
    logic [c_to_w-1:0] to_cnt_q, to_cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [7:0]        b0_q, b0_d, b1_q, b1_d, b2_q, b2_d;
    logic              tx_req_q, tx_req_d, ready_q, ready_d;
    logic [7:0]        tx_byte_q, tx_byte_d, err_cnt_q, err_cnt_d;
    logic              wheel_mode_q, wheel_mode_d, pkt_valid_q, pkt_valid_d;
    logic [8:0]        dx_q, dx_d, dy_q, dy_d;
    logic [3:0]        dz_q, dz_d;
    logic [2:0]        buttons_q, buttons_d;
    logic [1:0]        ovf_q, ovf_d;

    logic       w_rx, w_to, w_to_run, err_inc, restart;
    logic [7:0] w_cmd, w_expect, w_b2;
    logic [3:0] w_dz;

    // Pulses are only meaningful once a command has gone out after reset.
    assign w_rx     = rx_done & armed_q;
    assign w_to_run = !(state_q == ST_STREAM && idx_q == 2'd0);
    assign w_to     = w_to_run && (to_cnt_q == c_to_last);
    assign w_b2     = (idx_q == 2'd3) ? b2_q : rx_byte;
    assign w_dz     = (idx_q == 2'd3) ? rx_byte[3:0] : 4'h0;

    always_comb begin
        w_cmd     = 8'hFF;
        w_expect  = 8'hFA;
        w_tx_next = ST_RST_ACK;
        case (state_q)
            ST_SR_TX: begin
                w_tx_next = ST_SR_ACK;
                case (sr_idx_q)
                    3'd1:    w_cmd = 8'hC8;
                    3'd3:    w_cmd = 8'h64;
                    3'd5:    w_cmd = 8'h50;
                    default: w_cmd = 8'hF3;
                endcase
            end
            ST_ID_TX: begin w_cmd = 8'hF2; w_tx_next = ST_ID_ACK; end
            ST_EN_TX: begin w_cmd = 8'hF4; w_tx_next = ST_EN_ACK; end
            ST_BAT:   w_expect = 8'hAA;
            ST_ID0:   w_expect = 8'h00;
            default:  ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        sent_d       = sent_q;
        armed_d      = armed_q;
        sr_idx_d     = sr_idx_q;
        idx_d        = idx_q;
        b0_d         = b0_q;
        b1_d         = b1_q;
        b2_d         = b2_q;
        tx_req_d     = 1'b0;
        tx_byte_d    = tx_byte_q;
        wheel_mode_d = wheel_mode_q;
        pkt_valid_d  = 1'b0;
        dx_d         = dx_q;
        dy_d         = dy_q;
        dz_d         = dz_q;
        buttons_d    = buttons_q;
        ovf_d        = ovf_q;
        err_cnt_d    = err_cnt_q;
        err_inc      = 1'b0;
        restart      = 1'b0;
        to_cnt_d     = w_to_run ? to_cnt_q + 1'b1 : '0;

        case (state_q)
            ST_RST_TX, ST_SR_TX, ST_ID_TX, ST_EN_TX: begin
                if (!sent_q) begin
                    tx_req_d  = 1'b1;
                    tx_byte_d = w_cmd;
                    sent_d    = 1'b1;
                    armed_d   = 1'b1;
                end else if (tx_done) begin
                    state_d = w_tx_next;
                end else if (w_to) begin
                    restart = 1'b1;
                end
            end
            ST_RST_ACK, ST_BAT, ST_ID0, ST_SR_ACK, ST_ID_ACK, ST_ID_RX, ST_EN_ACK: begin
                if (w_rx) begin
                    if (state_q != ST_ID_RX && rx_byte != w_expect) begin
                        restart = 1'b1;
                    end else begin
                        case (state_q)
                            ST_RST_ACK: state_d = ST_BAT;
                            ST_BAT:     state_d = ST_ID0;
                            ST_ID0: begin
                                state_d  = (WHEEL != 0) ? ST_SR_TX : ST_EN_TX;
                                sr_idx_d = '0;
                            end
                            ST_SR_ACK: begin
                                if (sr_idx_q == 3'd5) begin
                                    state_d = ST_ID_TX;
                                end else begin
                                    state_d  = ST_SR_TX;
                                    sr_idx_d = sr_idx_q + 1'b1;
                                end
                            end
                            ST_ID_ACK:  state_d = ST_ID_RX;
                            ST_ID_RX: begin
                                wheel_mode_d = (rx_byte == 8'h03);
                                state_d      = ST_EN_TX;
                            end
                            default: begin
                                state_d = ST_STREAM;
                                idx_d   = 2'd0;
                            end
                        endcase
                    end
                end else if (w_to) begin
                    restart = 1'b1;
                end
            end
            ST_STREAM: begin
                // A received byte always beats a coincident gap timeout.
                if (w_rx) begin
                    if (idx_q == 2'd0) begin
                        if (rx_byte == 8'hAA) begin
                            state_d      = ST_ID0;
                            wheel_mode_d = 1'b0;
                        end else if (!rx_byte[3]) begin
                            err_inc = 1'b1;
                        end else begin
                            b0_d  = rx_byte;
                            idx_d = 2'd1;
                        end
                    end else if (idx_q == 2'd1) begin
                        b1_d  = rx_byte;
                        idx_d = 2'd2;
                    end else if (idx_q == 2'd2 && wheel_mode_q) begin
                        b2_d  = rx_byte;
                        idx_d = 2'd3;
                    end else begin
                        idx_d       = 2'd0;
                        pkt_valid_d = 1'b1;
                        dx_d        = {b0_q[4], b1_q};
                        dy_d        = {b0_q[5], w_b2};
                        dz_d        = w_dz;
                        buttons_d   = b0_q[2:0];
                        ovf_d       = b0_q[7:6];
                    end
                end else if (w_to && idx_q != 2'd0) begin
                    idx_d   = 2'd0;
                    err_inc = 1'b1;
                end
            end
            default: state_d = ST_RST_TX;
        endcase

        if (restart) begin
            state_d      = ST_RST_TX;
            sent_d       = 1'b0;
            err_inc      = 1'b1;
            wheel_mode_d = 1'b0;
        end
        if (state_d != state_q) sent_d = 1'b0;
        if (restart || state_d != state_q || w_rx) to_cnt_d = '0;
        if (err_inc && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 1'b1;
        ready_d = (state_d == ST_STREAM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RST_TX;
            sent_q       <= 1'b0;
            armed_q      <= 1'b0;
            sr_idx_q     <= '0;
            to_cnt_q     <= '0;
            idx_q        <= '0;
            b0_q         <= '0;
            b1_q         <= '0;
            b2_q         <= '0;
            tx_req_q     <= 1'b0;
            tx_byte_q    <= 8'h00;
            ready_q      <= 1'b0;
            wheel_mode_q <= 1'b0;
            pkt_valid_q  <= 1'b0;
            dx_q         <= '0;
            dy_q         <= '0;
            dz_q         <= '0;
            buttons_q    <= '0;
            ovf_q        <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            sent_q       <= sent_d;
            armed_q      <= armed_d;
            sr_idx_q     <= sr_idx_d;
            to_cnt_q     <= to_cnt_d;
            idx_q        <= idx_d;
            b0_q         <= b0_d;
            b1_q         <= b1_d;
            b2_q         <= b2_d;
            tx_req_q     <= tx_req_d;
            tx_byte_q    <= tx_byte_d;
            ready_q      <= ready_d;
            wheel_mode_q <= wheel_mode_d;
            pkt_valid_q  <= pkt_valid_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            dz_q         <= dz_d;
            buttons_q    <= buttons_d;
            ovf_q        <= ovf_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign tx_req     = tx_req_q;
    assign tx_byte    = tx_byte_q;
    assign ready      = ready_q;
    assign wheel_mode = wheel_mode_q;
    assign pkt_valid  = pkt_valid_q;
    assign dx         = dx_q;
    assign dy         = dy_q;
    assign dz         = dz_q;
    assign buttons    = buttons_q;
    assign ovf        = ovf_q;
    assign err_cnt    = err_cnt_q;

`ifdef PS2_MOUSE_ACCUM_EN
    logic signed [POS_W+1:0] sum_x, sum_y;
    logic [POS_W-1:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic                    unused_bits;

    // Cursor Y grows downward while dy is positive-up, hence the subtraction.
    always_comb begin
        sum_x   = $signed({2'b00, pos_x_q}) + $signed({{(POS_W-7){dx_d[8]}}, dx_d});
        sum_y   = $signed({2'b00, pos_y_q}) - $signed({{(POS_W-7){dy_d[8]}}, dy_d});
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        if (pkt_valid_d && !ovf_d[0]) begin
            if (sum_x[POS_W+1])      pos_x_d = '0;
            else if (sum_x > c_x_max) pos_x_d = c_x_max[POS_W-1:0];
            else                     pos_x_d = sum_x[POS_W-1:0];
        end
        if (pkt_valid_d && !ovf_d[1]) begin
            if (sum_y[POS_W+1])      pos_y_d = '0;
            else if (sum_y > c_y_max) pos_y_d = c_y_max[POS_W-1:0];
            else                     pos_y_d = sum_y[POS_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_x_q <= '0;
            pos_y_q <= '0;
        end else begin
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
        end
    end

    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign unused_bits = b0_q[3];
`else
    logic unused_bits;
    assign pos_x       = '0;
    assign pos_y       = '0;
    assign unused_bits = ^{b0_q[3], c_x_max, c_y_max};
`endif

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_mouse_ctrl
// Brief    : Bench for ps2_mouse_ctrl; unit 0 built with WHEEL=0, unit 1 with
//            WHEEL=1, packets checked against a scoreboard queue.
// Revision : 1.0  initial release
// ============================================================================
module tb_ps2_mouse_ctrl;

`ifdef PS2_MOUSE_ACCUM_EN
    localparam int ACC = 1;
`else
    localparam int ACC = 0;
`endif

    logic       clk = 1'b0;
    logic       reset     [2];
    logic       tx_done   [2];
    logic       rx_done   [2];
    logic [7:0] rx_byte   [2];
    logic       tx_req    [2];
    logic [7:0] tx_byte   [2];
    logic       ready     [2];
    logic       wheel_mode[2];
    logic       pkt_valid [2];
    logic [8:0] dx        [2];
    logic [8:0] dy        [2];
    logic [3:0] dz        [2];
    logic [2:0] buttons   [2];
    logic [1:0] ovf       [2];
    logic [7:0] err_cnt   [2];
    logic [9:0] pos_x     [2];
    logic [9:0] pos_y     [2];

    typedef struct {
        int         u;
        logic [8:0] dx;
        logic [8:0] dy;
        logic [3:0] dz;
        logic [2:0] btn;
        logic [1:0] ovf;
    } pkt_t;

    pkt_t       sb[$];
    logic [7:0] txq0[$];
    logic [7:0] txq1[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ps2_mouse_ctrl #(
            .CLK_HZ(50_000), .TIMEOUT_MS(20), .WHEEL(g),
            .POS_W(10), .X_MAX(639), .Y_MAX(479)
        ) u_dut (
            .clk(clk), .reset(reset[g]),
            .tx_req(tx_req[g]), .tx_byte(tx_byte[g]), .tx_done(tx_done[g]),
            .rx_done(rx_done[g]), .rx_byte(rx_byte[g]),
            .ready(ready[g]), .wheel_mode(wheel_mode[g]), .pkt_valid(pkt_valid[g]),
            .dx(dx[g]), .dy(dy[g]), .dz(dz[g]), .buttons(buttons[g]), .ovf(ovf[g]),
            .err_cnt(err_cnt[g]), .pos_x(pos_x[g]), .pos_y(pos_y[g])
        );
    end

    always @(negedge clk) begin
        if (tx_req[0]) txq0.push_back(tx_byte[0]);
        if (tx_req[1]) txq1.push_back(tx_byte[1]);
    end

    always @(negedge clk) begin : mon
        pkt_t e;
        for (int u = 0; u < 2; u++) begin
            if (pkt_valid[u]) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL pkt_unexpected u%0d dx=%h dy=%h btn=%b", u, dx[u], dy[u], buttons[u]);
                end else begin
                    e = sb.pop_front();
                    if (e.u != u || {dx[u], dy[u], dz[u], buttons[u], ovf[u]} !== {e.dx, e.dy, e.dz, e.btn, e.ovf}) begin
                        n_bad++;
                        $display("FAIL pkt_fields u%0d got dx=%h dy=%h dz=%h btn=%b ovf=%b want u%0d dx=%h dy=%h dz=%h btn=%b ovf=%b",
                                 u, dx[u], dy[u], dz[u], buttons[u], ovf[u], e.u, e.dx, e.dy, e.dz, e.btn, e.ovf);
                    end
                end
            end
        end
    end

    function automatic void expect_pkt(int u, logic [8:0] ex, logic [8:0] ey, logic [3:0] ez,
                                       logic [2:0] eb, logic [1:0] eo);
        pkt_t p;
        p.u = u; p.dx = ex; p.dy = ey; p.dz = ez; p.btn = eb; p.ovf = eo;
        sb.push_back(p);
    endfunction

    task automatic send_rx(input int u, input logic [7:0] b);
        @(negedge clk);
        rx_done[u] = 1'b1;
        rx_byte[u] = b;
        @(negedge clk);
        rx_done[u] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic host_cmd(input int u, output logic [7:0] b, output bit got);
        got = 1'b0;
        b   = 8'h00;
        for (int i = 0; i < 4000 && !got; i++) begin
            @(negedge clk);
            if (u == 0 && txq0.size() > 0) begin b = txq0.pop_front(); got = 1'b1; end
            else if (u == 1 && txq1.size() > 0) begin b = txq1.pop_front(); got = 1'b1; end
        end
        if (got) begin
            repeat (2) @(negedge clk);
            tx_done[u] = 1'b1;
            @(negedge clk);
            tx_done[u] = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic do_reset(input int u);
        @(negedge clk);
        reset[u] = 1'b1;
        repeat (3) @(negedge clk);
        reset[u] = 1'b0;
        if (u == 0) txq0.delete(); else txq1.delete();
    endtask

    task automatic run_init(input int u, input bit wheel, input logic [7:0] id);
        logic [7:0] seq [9];
        logic [7:0] b, exp_b;
        bit         got;
        int         n;
        seq = '{8'hFF, 8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF2, 8'hF4};
        n   = wheel ? 9 : 2;
        for (int i = 0; i < n; i++) begin
            exp_b = wheel ? seq[i] : ((i == 0) ? 8'hFF : 8'hF4);
            host_cmd(u, b, got);
            n_cmp++;
            if (!got || b !== exp_b) begin
                n_bad++;
                $display("FAIL init_tx u%0d step%0d got=%h seen=%0d want=%h", u, i, b, got, exp_b);
            end
            send_rx(u, 8'hFA);
            if (i == 0) begin send_rx(u, 8'hAA); send_rx(u, 8'h00); end
            if (wheel && i == 7) send_rx(u, id);
        end
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            n_cmp++;
            if ({tx_req[u], tx_byte[u], ready[u], wheel_mode[u], pkt_valid[u], dx[u], dy[u], dz[u],
                 buttons[u], ovf[u], err_cnt[u], pos_x[u], pos_y[u]} !== 67'd0) begin
                n_bad++;
                $display("FAIL reset_outputs u%0d got tx_byte=%h err=%h ready=%b want all zero",
                         u, tx_byte[u], err_cnt[u], ready[u]);
            end
        end
        @(negedge clk);
        reset[0] = 1'b0;
    endtask

    task automatic test_init_plain();
        run_init(0, 1'b0, 8'h00);
        n_cmp++;
        if ({ready[0], wheel_mode[0]} !== 2'b10) begin
            n_bad++;
            $display("FAIL init_plain ready/wheel got=%b%b want=10", ready[0], wheel_mode[0]);
        end
    endtask

    task automatic test_resync();
        send_rx(0, 8'h00);
        n_cmp++;
        if (err_cnt[0] !== 8'd1) begin
            n_bad++;
            $display("FAIL resync_err got=%0d want=1", err_cnt[0]);
        end
        expect_pkt(0, 9'h010, 9'h020, 4'h0, 3'b001, 2'b00);
        send_rx(0, 8'h09); send_rx(0, 8'h10); send_rx(0, 8'h20);
    endtask

    task automatic test_stream_timeout();
        send_rx(0, 8'h08); send_rx(0, 8'h11);
        repeat (1200) @(negedge clk);
        n_cmp++;
        if (err_cnt[0] !== 8'd2) begin
            n_bad++;
            $display("FAIL stream_timeout_err got=%0d want=2", err_cnt[0]);
        end
        expect_pkt(0, 9'h1F0, 9'h110, 4'h0, 3'b000, 2'b00);
        send_rx(0, 8'h38); send_rx(0, 8'hF0); send_rx(0, 8'h10);
    endtask

    task automatic test_hot_replug();
        logic [7:0] b;
        bit         got;
        send_rx(0, 8'hAA);
        n_cmp++;
        if ({ready[0], wheel_mode[0]} !== 2'b00) begin
            n_bad++;
            $display("FAIL replug_ready got=%b%b want=00", ready[0], wheel_mode[0]);
        end
        send_rx(0, 8'h00);
        host_cmd(0, b, got);
        n_cmp++;
        if (!got || b !== 8'hF4) begin
            n_bad++;
            $display("FAIL replug_enable got=%h seen=%0d want=f4", b, got);
        end
        send_rx(0, 8'hFA);
        n_cmp++;
        if (ready[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL replug_ready_again got=%b want=1", ready[0]);
        end
    endtask

    task automatic test_init_wheel();
        do_reset(1);
        run_init(1, 1'b1, 8'h03);
        n_cmp++;
        if ({ready[1], wheel_mode[1]} !== 2'b11) begin
            n_bad++;
            $display("FAIL init_wheel ready/wheel got=%b%b want=11", ready[1], wheel_mode[1]);
        end
        expect_pkt(1, 9'h005, 9'h1FE, 4'hF, 3'b000, 2'b00);
        send_rx(1, 8'h28); send_rx(1, 8'h05); send_rx(1, 8'hFE); send_rx(1, 8'h0F);
    endtask

    task automatic test_bad_ack();
        logic [7:0] b;
        bit         got;
        do_reset(1);
        host_cmd(1, b, got);
        send_rx(1, 8'hFA); send_rx(1, 8'hAA); send_rx(1, 8'h00);
        host_cmd(1, b, got);
        n_cmp++;
        if (!got || b !== 8'hF3) begin
            n_bad++;
            $display("FAIL bad_ack_first_sr got=%h seen=%0d want=f3", b, got);
        end
        send_rx(1, 8'hFE);
        n_cmp++;
        if (err_cnt[1] !== 8'd1) begin
            n_bad++;
            $display("FAIL bad_ack_err got=%0d want=1", err_cnt[1]);
        end
        host_cmd(1, b, got);
        n_cmp++;
        if (!got || b !== 8'hFF) begin
            n_bad++;
            $display("FAIL bad_ack_restart got=%h seen=%0d want=ff", b, got);
        end
        // no reply: the ack wait must time out and restart with another FF
        run_init(1, 1'b1, 8'h00);
        n_cmp++;
        if ({err_cnt[1], ready[1], wheel_mode[1]} !== {8'd2, 2'b10}) begin
            n_bad++;
            $display("FAIL timeout_restart err=%0d ready=%b wheel=%b want err=2 ready=1 wheel=0",
                     err_cnt[1], ready[1], wheel_mode[1]);
        end
        expect_pkt(1, 9'h07F, 9'h081, 4'h0, 3'b111, 2'b00);
        send_rx(1, 8'h0F); send_rx(1, 8'h7F); send_rx(1, 8'h81);
    endtask

    task automatic test_accum();
        do_reset(0);
        run_init(0, 1'b0, 8'h00);
        n_cmp++;
        if ({pos_x[0], pos_y[0]} !== 20'd0) begin
            n_bad++;
            $display("FAIL accum_start got=(%0d,%0d) want=(0,0)", pos_x[0], pos_y[0]);
        end
        expect_pkt(0, 9'h1FB, 9'h000, 4'h0, 3'b000, 2'b00);
        send_rx(0, 8'h18); send_rx(0, 8'hFB); send_rx(0, 8'h00);
        n_cmp++;
        if (pos_x[0] !== 10'd0) begin
            n_bad++;
            $display("FAIL accum_low_clamp got=%0d want=0", pos_x[0]);
        end
        for (int i = 0; i < 30; i++) begin
            expect_pkt(0, 9'h01E, 9'h000, 4'h0, 3'b000, 2'b00);
            send_rx(0, 8'h08); send_rx(0, 8'h1E); send_rx(0, 8'h00);
        end
        n_cmp++;
        if (pos_x[0] !== ((ACC != 0) ? 10'd639 : 10'd0)) begin
            n_bad++;
            $display("FAIL accum_high_clamp got=%0d want=%0d", pos_x[0], (ACC != 0) ? 639 : 0);
        end
        expect_pkt(0, 9'h100, 9'h000, 4'h0, 3'b000, 2'b01);
        send_rx(0, 8'h58); send_rx(0, 8'h00); send_rx(0, 8'h00);
        expect_pkt(0, 9'h000, 9'h1F6, 4'h0, 3'b000, 2'b00);
        send_rx(0, 8'h28); send_rx(0, 8'h00); send_rx(0, 8'hF6);
        n_cmp++;
        if ({pos_x[0], pos_y[0]} !== ((ACC != 0) ? {10'd639, 10'd10} : 20'd0)) begin
            n_bad++;
            $display("FAIL accum_ovf_and_y got=(%0d,%0d) want=(%0d,%0d)", pos_x[0], pos_y[0],
                     (ACC != 0) ? 639 : 0, (ACC != 0) ? 10 : 0);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        bit         got;
        send_rx(0, 8'h08); send_rx(0, 8'h05);
        @(negedge clk);
        reset[0] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({tx_req[0], tx_byte[0], ready[0], wheel_mode[0], pkt_valid[0], dx[0], dy[0], dz[0],
             buttons[0], ovf[0], err_cnt[0], pos_x[0], pos_y[0]} !== 67'd0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs got dx=%h pos_x=%0d err=%0d want all zero",
                     dx[0], pos_x[0], err_cnt[0]);
        end
        repeat (2) @(negedge clk);
        reset[0] = 1'b0;
        txq0.delete();
        host_cmd(0, b, got);
        n_cmp++;
        if (!got || b !== 8'hFF) begin
            n_bad++;
            $display("FAIL reset_mid_restart got=%h seen=%0d want=ff", b, got);
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            reset[u] = 1'b1; tx_done[u] = 1'b0; rx_done[u] = 1'b0; rx_byte[u] = 8'h00;
        end
        repeat (3) @(negedge clk);
        test_reset();
        test_init_plain();
        test_resync();
        test_stream_timeout();
        test_hot_replug();
        test_init_wheel();
        test_bad_ack();
        test_accum();
        test_reset_mid();
        repeat (10) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL pkt_missing got=%0d outstanding want=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=time limit want=finish before limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
